// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master and its bus interface.
package apb_pkg;

   localparam int unsigned APB_ADDR_WIDTH     = 32;
   localparam int unsigned APB_DATA_WIDTH     = 32;
   localparam int unsigned APB_TIMEOUT_CYCLES = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB bus signals of the APB master, with
// the master (design) and slave (environment) views.
interface apb_master_if
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [STRB_WIDTH-1:0] req_strobe;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;
   logic                  sel;
   logic                  enable;
   logic                  write;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] strobe;
   logic                  ready;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  slverr;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_strobe, rsp_ready,
             ready, rdata, slverr,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, sel, enable, write,
             addr, wdata, strobe
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_strobe, rsp_ready,
             ready, rdata, slverr,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, sel, enable, write,
             addr, wdata, strobe
   );

endinterface

// File: rtl/apb_timeout.sv
// Counts consecutive ACCESS wait cycles; flags the cycle that reaches the limit.
module apb_timeout
   import apb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic cnt_en_i,
   output logic timeout_c_o
);
   localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   // The current wait cycle is the last allowed one when the count already holds limit-1.
   assign timeout_c_o = cnt_en_i && (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_en_i && !timeout_c_o) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: command handshake in, APB transfer, registered response out.
// Optional ACCESS wait-state timeout is built when APB_TIMEOUT_EN is defined.
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
   input logic          clk,
   input logic          rst_n,
   apb_master_if.master bus
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   apb_state_e            state_q, state_d;
   logic                  sel_q, sel_d;
   logic                  enable_q, enable_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] strobe_q, strobe_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;

   logic rsp_free_c;
   logic req_ready_c;
   logic accept_c;
   logic done_c;
   logic timeout_c;

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("apb_master: TIMEOUT_CYCLES must be nonzero");
   end

   // A new command may only be taken when its eventual response has somewhere to go.
   assign rsp_free_c  = !rsp_valid_q || bus.rsp_ready;
   assign req_ready_c = rsp_free_c &&
                        ((state_q == IDLE) || ((state_q == ACCESS) && bus.ready));
   assign accept_c    = bus.req_valid && req_ready_c;
   assign done_c      = (state_q == ACCESS) && bus.ready;

`ifdef APB_TIMEOUT_EN
   apb_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (state_q == SETUP),
      .cnt_en_i    ((state_q == ACCESS) && !bus.ready),
      .timeout_c_o (timeout_c)
   );
`else
   assign timeout_c = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_c) state_d = SETUP;
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (done_c) begin
               state_d = accept_c ? SETUP : IDLE;
            end else if (timeout_c) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Next values of the registered bus and response outputs.
   always_comb begin
      sel_d       = 1'b0;
      enable_d    = 1'b0;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      strobe_d    = strobe_q;
      rsp_valid_d = rsp_valid_q && !bus.rsp_ready;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      case (state_d)
         SETUP: begin
            sel_d = 1'b1;
         end
         ACCESS: begin
            sel_d    = 1'b1;
            enable_d = 1'b1;
         end
         default: begin
            sel_d = 1'b0;
         end
      endcase

      if (accept_c) begin
         write_d  = bus.req_write;
         addr_d   = bus.req_addr;
         wdata_d  = bus.req_wdata;
         strobe_d = bus.req_write ? bus.req_strobe : '0;
      end

      if (done_c || timeout_c) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = done_c ? bus.slverr : 1'b1;
         rsp_rdata_d = (done_c && !write_q && !bus.slverr) ? bus.rdata : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel_q       <= 1'b0;
         enable_q    <= 1'b0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         strobe_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         sel_q       <= sel_d;
         enable_q    <= enable_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         strobe_q    <= strobe_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.req_ready = req_ready_c;
   assign bus.sel       = sel_q;
   assign bus.enable    = enable_q;
   assign bus.write     = write_q;
   assign bus.addr      = addr_q;
   assign bus.wdata     = wdata_q;
   assign bus.strobe    = strobe_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: command and APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum ACCESS wait cycles, used only when APB_TIMEOUT_EN is defined.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
 clk  in  1  single clock; all logic on its rising edge
 rst_n  in  1  reset, synchronous, active-low
 req_valid  in  1  command valid
 req_ready  out  1  command accepted when req_valid & req_ready
 req_write  in  1  1 = write, 0 = read
 req_addr  in  ADDR_WIDTH  byte address
 req_wdata  in  DATA_WIDTH  write data
 req_strobe  in  DATA_WIDTH/8  write byte lanes
 rsp_valid  out  1  response valid, held until rsp_ready
 rsp_ready  in  1  response consumed
 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
 rsp_err  out  1  slave error or timeout
 sel  out  1  APB select
 enable  out  1  APB enable
 write  out  1  APB direction
 addr  out  ADDR_WIDTH  APB address
 wdata  out  DATA_WIDTH  APB write data
 strobe  out  DATA_WIDTH/8  APB byte strobes
 ready  in  1  APB slave ready
 rdata  in  DATA_WIDTH  APB read data
 slverr  in  1  APB slave error

Function
REQ-005 SHALL implement a three-state FSM: IDLE, SETUP, ACCESS.
REQ-006 SHALL drive req_ready = 1 in IDLE and in ACCESS with ready = 1, provided the response register is empty or is being drained in the same cycle (rsp_valid & rsp_ready).
REQ-007 SHALL register addr, write, wdata and strobe on command acceptance and hold them stable through SETUP and ACCESS.
REQ-008 SHALL drive strobe = 0 for reads, regardless of req_strobe.
REQ-009 SHALL transition IDLE->SETUP on acceptance; SETUP->ACCESS unconditionally after one cycle.
REQ-010 SHALL drive sel=1, enable=0 in SETUP, and sel=1, enable=1 in ACCESS.
REQ-011 SHALL hold ACCESS while ready = 0 (wait states).
REQ-012 SHALL, in ACCESS with ready = 1, go to SETUP if a new command is accepted in that cycle; otherwise go to IDLE.
REQ-013 SHALL, on completion, load rsp_rdata = rdata (reads with slverr=0) or 0 (otherwise), load rsp_err = slverr, and set rsp_valid the following cycle.
REQ-014 SHALL set minimum latency from acceptance at cycle N to: SETUP at N+1, ACCESS at N+2, and rsp_valid at N+3 when ready=1 at N+2.
REQ-015 SHALL hold rsp_valid, rsp_rdata and rsp_err until rsp_ready; rsp_valid clears the cycle after the handshake unless a new completion loads the register in the same cycle.
REQ-016 SHALL drive sel=0, enable=0 in IDLE, with addr, wdata and strobe holding their last values.

Reset
REQ-017 SHALL, when rst_n=0 at a clock edge, force state IDLE, sel=0, enable=0, write=0, addr=0, wdata=0, strobe=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and clear the timeout counter.
REQ-018 SHALL drop an in-flight transfer when reset is asserted mid-transfer, without generating a response.

Configuration
REQ-019 SHALL, with APB_TIMEOUT_EN defined, count consecutive ACCESS cycles with ready=0.
REQ-020 SHALL, on reaching TIMEOUT_CYCLES, terminate the transfer to IDLE with rsp_err=1 and rsp_rdata=0; the counter clears on each SETUP.
REQ-021 SHALL, without APB_TIMEOUT_EN, contain no counter and wait in ACCESS indefinitely.

Structure
REQ-022 SHALL take ADDR_WIDTH/DATA_WIDTH defaults and the state enum type (IDLE, SETUP, ACCESS) from the shared package apb_pkg.
REQ-023 SHALL place the timeout counter in sub-module apb_timeout, instantiated only under APB_TIMEOUT_EN.

Verification
REQ-024 Write: addr=0x10, wdata=0xDEADBEEF, strobe=0xF, ready=1 -> SETUP at N+1, ACCESS at N+2, rsp_valid at N+3 with rsp_err=0.
REQ-025 Read with 3 wait states: rdata=0x12345678 -> enable held high for 4 cycles, rsp_rdata=0x12345678.
REQ-026 Back-to-back: two commands issued, rsp_ready=1 -> ACCESS->SETUP with no IDLE cycle; second addr appears in the cycle after the first ready.
REQ-027 Response stall: rsp_ready=0 -> req_ready=0 after the first completion; no second SETUP until the response is drained.
REQ-028 slverr=1 on read -> rsp_err=1, rsp_rdata=0; with APB_TIMEOUT_EN, TIMEOUT_CYCLES=4 and ready tied 0 -> rsp_err=1 after 4 ACCESS cycles.
REQ-029 rst_n=0 during ACCESS -> sel=0 and enable=0 after the next edge, and no rsp_valid is generated.
